// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - widths, opcodes, reset constants and FSM encoding for the execute stage
package exe_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int ALUOP_W = 4;

    localparam logic [DATA_W-1:0] ZeroWord    = '0;
    localparam logic [ADDR_W-1:0] ZeroRegAddr = '0;
    localparam logic              RstEnable   = 1'b1;

    localparam logic [ALUOP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [ALUOP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [ALUOP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [ALUOP_W-1:0] OP_AND  = 4'd3;
    localparam logic [ALUOP_W-1:0] OP_OR   = 4'd4;
    localparam logic [ALUOP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] OP_SLL  = 4'd6;
    localparam logic [ALUOP_W-1:0] OP_SRL  = 4'd7;
    localparam logic [ALUOP_W-1:0] OP_SRA  = 4'd8;
    localparam logic [ALUOP_W-1:0] OP_SLT  = 4'd9;
    localparam logic [ALUOP_W-1:0] OP_SLTU = 4'd10;
    localparam logic [ALUOP_W-1:0] OP_MUL  = 4'd11;

    localparam logic [4:0] MUL_LAST = 5'd31;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } mul_state_e;

    // EX/MEM beats MEM/WB beats the register file; x0 is hard zero.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              mem_we,
        input logic [ADDR_W-1:0] mem_addr,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        if (src == ZeroRegAddr)
            return ZeroWord;
        else if (mem_we && (mem_addr == src))
            return mem_data;
        else if (wb_we && (wb_addr == src))
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// rtl/exe_mul_iter.sv - 32-step shift-add multiplier with start/abort/done
module exe_mul_iter
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              last,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    mul_state_e        state;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;

    assign busy    = (state == S_MUL_BUSY);
    assign last    = (cnt == MUL_LAST);
    assign done    = busy & last & ~abort;
    // Accumulator after the current step; on the final step this is the product.
    assign product = acc + (mplier[0] ? mcand : ZeroWord);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            mcand  <= ZeroWord;
            mplier <= ZeroWord;
            acc    <= ZeroWord;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= ZeroWord;
                        cnt    <= 5'd0;
                        state  <= S_MUL_BUSY;
                    end
                end
                S_MUL_BUSY: begin
                    if (abort) begin
                        cnt   <= 5'd0;
                        state <= S_IDLE;
                    end else begin
                        acc    <= product;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (last) begin
                            cnt   <= 5'd0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: forwarding, ALU, EX/MEM registers; EXE_MUL_EN adds an iterative multiplier
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic               clk_i_EXE,
    input  logic               rst_i_EXE,
    input  logic               valid_i_EXE,
    input  logic [ALUOP_W-1:0] ALUOp_i_EXE,
    input  logic               regWrite_i_EXE,
    input  logic               useImm_i_EXE,
    input  logic [DATA_W-1:0]  immSignExtend_i_EXE,
    input  logic [ADDR_W-1:0]  Rd_Addr1_i_EXE,
    input  logic [ADDR_W-1:0]  Rd_Addr2_i_EXE,
    input  logic [DATA_W-1:0]  Rd_Data1_i_EXE,
    input  logic [DATA_W-1:0]  Rd_Data2_i_EXE,
    input  logic [ADDR_W-1:0]  Wr_Addr_i_EXE,
    input  logic               flush_i_EXE,
    input  logic               fwdMemWrite_i_EXE,
    input  logic [ADDR_W-1:0]  fwdMemAddr_i_EXE,
    input  logic [DATA_W-1:0]  fwdMemData_i_EXE,
    input  logic               fwdWbWrite_i_EXE,
    input  logic [ADDR_W-1:0]  fwdWbAddr_i_EXE,
    input  logic [DATA_W-1:0]  fwdWbData_i_EXE,
    output logic               stall_o_EXE,
    output logic               valid_o_EXE,
    output logic               regWrite_o_EXE,
    output logic [ADDR_W-1:0]  Wr_Addr_o_EXE,
    output logic [DATA_W-1:0]  aluResult_o_EXE
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              op_legal;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign op_a = fwd_operand(Rd_Addr1_i_EXE, Rd_Data1_i_EXE,
                              fwdMemWrite_i_EXE, fwdMemAddr_i_EXE, fwdMemData_i_EXE,
                              fwdWbWrite_i_EXE, fwdWbAddr_i_EXE, fwdWbData_i_EXE);
    assign rs2_val = fwd_operand(Rd_Addr2_i_EXE, Rd_Data2_i_EXE,
                                 fwdMemWrite_i_EXE, fwdMemAddr_i_EXE, fwdMemData_i_EXE,
                                 fwdWbWrite_i_EXE, fwdWbAddr_i_EXE, fwdWbData_i_EXE);
    assign op_b = useImm_i_EXE ? immSignExtend_i_EXE : rs2_val;

    always_comb begin
        alu_res  = ZeroWord;
        op_legal = 1'b1;
        case (ALUOp_i_EXE)
            OP_NOP:  alu_res = ZeroWord;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[4:0];
            OP_SRL:  alu_res = op_a >> op_b[4:0];
            OP_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
`ifdef EXE_MUL_EN
            // The product arrives from the multiplier; this path is never written for MUL.
            OP_MUL:  alu_res = ZeroWord;
`endif
            default: op_legal = 1'b0;
        endcase
    end

`ifdef EXE_MUL_EN
    logic              mul_start;
    logic              mul_busy;
    logic              mul_last;
    logic              mul_rw;
    logic [ADDR_W-1:0] mul_rd;

    assign mul_start = ~mul_busy & valid_i_EXE & (ALUOp_i_EXE == OP_MUL) & ~flush_i_EXE;
    // Stall drops on the final step so ID/EXE advances on the same edge the product lands.
    assign stall_o_EXE = ~rst_i_EXE & (mul_start | (mul_busy & ~mul_last & ~flush_i_EXE));

    exe_mul_iter u_mul (
        .clk     (clk_i_EXE),
        .rst     (rst_i_EXE),
        .start   (mul_start),
        .abort   (flush_i_EXE),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (mul_busy),
        .last    (mul_last),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i_EXE or posedge rst_i_EXE) begin
        if (rst_i_EXE == RstEnable) begin
            mul_rw <= 1'b0;
            mul_rd <= ZeroRegAddr;
        end else if (mul_start) begin
            mul_rw <= regWrite_i_EXE;
            mul_rd <= Wr_Addr_i_EXE;
        end
    end
`else
    logic              mul_rw;
    logic [ADDR_W-1:0] mul_rd;

    assign stall_o_EXE = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = ZeroWord;
    assign mul_rw      = 1'b0;
    assign mul_rd      = ZeroRegAddr;
`endif

    always_ff @(posedge clk_i_EXE or posedge rst_i_EXE) begin
        if (rst_i_EXE == RstEnable) begin
            valid_o_EXE     <= 1'b0;
            regWrite_o_EXE  <= 1'b0;
            Wr_Addr_o_EXE   <= ZeroRegAddr;
            aluResult_o_EXE <= ZeroWord;
        end else if (mul_done) begin
            valid_o_EXE     <= 1'b1;
            regWrite_o_EXE  <= mul_rw;
            Wr_Addr_o_EXE   <= mul_rd;
            aluResult_o_EXE <= mul_product;
        end else if (stall_o_EXE || flush_i_EXE || !valid_i_EXE) begin
            valid_o_EXE     <= 1'b0;
            regWrite_o_EXE  <= 1'b0;
            Wr_Addr_o_EXE   <= ZeroRegAddr;
            aluResult_o_EXE <= ZeroWord;
        end else begin
            valid_o_EXE     <= 1'b1;
            regWrite_o_EXE  <= regWrite_i_EXE & op_legal;
            Wr_Addr_o_EXE   <= Wr_Addr_i_EXE;
            aluResult_o_EXE <= alu_res;
        end
    end

endmodule
